// File: rtl/t2mi_frame_scheduler.sv
// Per-T2-frame packet sequencer: requests L1-current then BB frames each frame, tracks frame/superframe/block indices.
// Define T2MI_TIMESTAMP_EN to prefix every frame with a timestamp (0x20) request.
module t2mi_frame_scheduler #(
    parameter int NB_W = 10,
    parameter int NF_W = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ENA,
    input  logic [NB_W-1:0] plp_num_blocks,
    input  logic [NF_W-1:0] num_t2_frames,
    input  logic            BBF_READY,
    input  logic            PKT_ACK,
    output logic            PKT_REQ,
    output logic [7:0]      PKT_TYPE,
    output logic [NF_W-1:0] FRAME_IDX,
    output logic [3:0]      SUPERFRAME_IDX,
    output logic [NB_W-1:0] BLOCK_IDX,
    output logic            FRAME_START,
    output logic            BUSY
);

    localparam logic [7:0] TYPE_BBF = 8'h00;
    localparam logic [7:0] TYPE_L1  = 8'h10;
    localparam logic [7:0] TYPE_TS  = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TS_REQ,
        S_L1_REQ,
        S_BBF_WAIT,
        S_BBF_REQ,
        S_GAP
    } state_t;

`ifdef T2MI_TIMESTAMP_EN
    localparam state_t     FIRST_REQ  = S_TS_REQ;
    localparam logic [7:0] FIRST_TYPE = TYPE_TS;
`else
    localparam state_t     FIRST_REQ  = S_L1_REQ;
    localparam logic [7:0] FIRST_TYPE = TYPE_L1;
`endif

    state_t          state_q;
    state_t          after_gap_q;
    logic            pkt_req_q;
    logic [7:0]      pkt_type_q;
    logic [NF_W-1:0] frame_idx_q;
    logic [3:0]      sf_idx_q;
    logic [NB_W-1:0] block_idx_q;
    logic            frame_start_q;
    logic            busy_q;
    logic [NB_W-1:0] blocks_q;
    logic [NF_W-1:0] frames_q;

    logic            ack_v;
    logic            blk_more;
    logic            frame_wrap;
    logic            frame_end;
    logic [NF_W-1:0] frame_idx_d;
    logic [3:0]      sf_idx_d;

    always_comb begin
        ack_v       = PKT_ACK && pkt_req_q;
        blk_more    = ({1'b0, block_idx_q} + (NB_W+1)'(1)) < {1'b0, blocks_q};
        // A latched frame count of 0 behaves like 1: every frame wraps.
        frame_wrap  = (frames_q <= NF_W'(1)) || (frame_idx_q == (frames_q - NF_W'(1)));
        frame_end   = ack_v && ENA &&
                      (((state_q == S_L1_REQ) && (blocks_q == '0)) ||
                       ((state_q == S_BBF_REQ) && !blk_more));
        frame_idx_d = frame_wrap ? '0 : frame_idx_q + NF_W'(1);
        sf_idx_d    = frame_wrap ? sf_idx_q + 4'd1 : sf_idx_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            after_gap_q   <= S_IDLE;
            pkt_req_q     <= 1'b0;
            pkt_type_q    <= TYPE_BBF;
            frame_idx_q   <= '0;
            sf_idx_q      <= '0;
            block_idx_q   <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            blocks_q      <= '0;
            frames_q      <= '0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ENA) begin
                        state_q       <= FIRST_REQ;
                        pkt_req_q     <= 1'b1;
                        pkt_type_q    <= FIRST_TYPE;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        blocks_q      <= plp_num_blocks;
                        frames_q      <= num_t2_frames;
                    end
                end
`ifdef T2MI_TIMESTAMP_EN
                S_TS_REQ,
`endif
                S_L1_REQ, S_BBF_REQ: begin
                    if (ack_v) begin
                        state_q   <= S_GAP;
                        pkt_req_q <= 1'b0;
                        if (!ENA) begin
                            after_gap_q <= S_IDLE;
                            frame_idx_q <= '0;
                            sf_idx_q    <= '0;
                            block_idx_q <= '0;
                        end else if (frame_end) begin
                            after_gap_q <= FIRST_REQ;
                            frame_idx_q <= frame_idx_d;
                            sf_idx_q    <= sf_idx_d;
                            block_idx_q <= '0;
                            blocks_q    <= plp_num_blocks;
                            frames_q    <= num_t2_frames;
                        end else if (state_q == S_BBF_REQ) begin
                            after_gap_q <= S_BBF_WAIT;
                            block_idx_q <= block_idx_q + NB_W'(1);
                        end else if (state_q == S_L1_REQ) begin
                            after_gap_q <= S_BBF_WAIT;
                            block_idx_q <= '0;
                        end else begin
                            after_gap_q <= S_L1_REQ;
                        end
                    end
                end
                S_BBF_WAIT: begin
                    if (!ENA) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_idx_q <= '0;
                        sf_idx_q    <= '0;
                        block_idx_q <= '0;
                    end else if (BBF_READY) begin
                        state_q    <= S_BBF_REQ;
                        pkt_req_q  <= 1'b1;
                        pkt_type_q <= TYPE_BBF;
                    end
                end
                S_GAP: begin
                    if (!ENA || (after_gap_q == S_IDLE)) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_idx_q <= '0;
                        sf_idx_q    <= '0;
                        block_idx_q <= '0;
                    end else begin
                        state_q <= after_gap_q;
                        if (after_gap_q != S_BBF_WAIT) begin
                            pkt_req_q     <= 1'b1;
`ifdef T2MI_TIMESTAMP_EN
                            pkt_type_q    <= (after_gap_q == S_TS_REQ) ? TYPE_TS : TYPE_L1;
`else
                            pkt_type_q    <= TYPE_L1;
`endif
                            frame_start_q <= (after_gap_q == FIRST_REQ);
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    pkt_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign PKT_REQ        = pkt_req_q;
    assign PKT_TYPE       = pkt_type_q;
    assign FRAME_IDX      = frame_idx_q;
    assign SUPERFRAME_IDX = sf_idx_q;
    assign BLOCK_IDX      = block_idx_q;
    assign FRAME_START    = frame_start_q;
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Randomized bench for t2mi_frame_scheduler: acts as the packet builder and checks each request against a frame-level model.
module tb_t2mi_frame_scheduler;

    localparam int NB_W = 10;
    localparam int NF_W = 8;
`ifdef T2MI_TIMESTAMP_EN
    localparam int FIRST_TYPE = 'h20;
`else
    localparam int FIRST_TYPE = 'h10;
`endif

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            ENA = 1'b0;
    logic            BBF_READY = 1'b1;
    logic            PKT_ACK = 1'b0;
    logic [NB_W-1:0] plp_num_blocks = '0;
    logic [NF_W-1:0] num_t2_frames = '0;
    logic            PKT_REQ;
    logic [7:0]      PKT_TYPE;
    logic [NF_W-1:0] FRAME_IDX;
    logic [3:0]      SUPERFRAME_IDX;
    logic [NB_W-1:0] BLOCK_IDX;
    logic            FRAME_START;
    logic            BUSY;

    t2mi_frame_scheduler #(.NB_W(NB_W), .NF_W(NF_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ENA            (ENA),
        .plp_num_blocks (plp_num_blocks),
        .num_t2_frames  (num_t2_frames),
        .BBF_READY      (BBF_READY),
        .PKT_ACK        (PKT_ACK),
        .PKT_REQ        (PKT_REQ),
        .PKT_TYPE       (PKT_TYPE),
        .FRAME_IDX      (FRAME_IDX),
        .SUPERFRAME_IDX (SUPERFRAME_IDX),
        .BLOCK_IDX      (BLOCK_IDX),
        .FRAME_START    (FRAME_START),
        .BUSY           (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int ts_seen  = 0;
    int cfg_nb, cfg_nf;
    bit drop_seen = 0;
    bit rst_seen  = 0;

    // Frame-level model: the next request the builder should see.
    int m_type, m_fidx, m_sf, m_blk, m_nb, m_nf;
    bit m_fs;

    always @(negedge CLK) if (PKT_REQ && PKT_TYPE == 8'h20) ts_seen++;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic void model_start();
        m_nb = cfg_nb; m_nf = cfg_nf;
        m_fidx = 0; m_sf = 0; m_blk = 0;
        m_type = FIRST_TYPE; m_fs = 1;
    endfunction

    function automatic void model_frame_end();
        bit wrap;
        wrap = (m_nf <= 1) || (m_fidx == m_nf - 1);
        m_fidx = wrap ? 0 : m_fidx + 1;
        if (wrap) m_sf = (m_sf + 1) % 16;
        m_blk = 0; m_nb = cfg_nb; m_nf = cfg_nf;
        m_type = FIRST_TYPE; m_fs = 1;
    endfunction

    function automatic void model_advance();
        m_fs = 0;
        case (m_type)
            'h20: m_type = 'h10;
            'h10: if (m_nb == 0) model_frame_end(); else begin m_type = 'h00; m_blk = 0; end
            default: if (m_blk + 1 < m_nb) m_blk = m_blk + 1; else model_frame_end();
        endcase
    endfunction

    task automatic set_cfg(input int nb, input int nf);
        cfg_nb = nb; cfg_nf = nf;
        plp_num_blocks = NB_W'(nb);
        num_t2_frames  = NF_W'(nf);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, PKT_REQ, 0);
        check({tag, "_type"}, PKT_TYPE, 0);
        check({tag, "_fidx"}, FRAME_IDX, 0);
        check({tag, "_sfidx"}, SUPERFRAME_IDX, 0);
        check({tag, "_blk"}, BLOCK_IDX, 0);
        check({tag, "_fstart"}, FRAME_START, 0);
        check({tag, "_busy"}, BUSY, 0);
    endtask

    // Plays the builder for n requests. Call with the model at the next expected request.
    task automatic run_requests(input int n, input bit do_drop, input int rst_at, input int stall_pct);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            int exp_gap;
            int hi = 0;
            int d;
            if (i > 0 && m_type == 'h00 && $urandom_range(0, 99) < stall_pct) begin
                BBF_READY = 1'b0;
                repeat (50) begin
                    tick();
                    PKT_ACK = ($urandom_range(0, 2) == 0);
                    if (PKT_REQ) hi++;
                end
                PKT_ACK = 1'b0;
                check("bbf_wait_req_high_cycles", hi, 0);
                BBF_READY = 1'b1;
                exp_gap = 1;
            end else begin
                exp_gap = (m_type == 'h00) ? 2 : 1;
            end
            while (!PKT_REQ && w < 100) begin
                tick();
                w++;
                PKT_ACK = 1'b0;
            end
            if (!PKT_REQ) begin
                check("req_timeout", 0, 1);
                return;
            end
            check("req_gap_cycles", w, exp_gap);
            check("req_type", PKT_TYPE, m_type);
            check("req_frame_idx", FRAME_IDX, m_fidx);
            check("req_sf_idx", SUPERFRAME_IDX, m_sf);
            check("req_block_idx", BLOCK_IDX, m_blk);
            check("req_frame_start", FRAME_START, m_fs);
            check("req_busy", BUSY, 1);
            if (rst_at == i) begin
                RST = 1'b1; ENA = 1'b0;
                tick();
                check_reset("rst_mid");
                RST = 1'b0;
                rst_seen = 1;
                return;
            end
            if (do_drop && m_type == 'h00 && m_blk == 1) begin
                ENA = 1'b0;
                repeat (3) begin
                    tick();
                    check("drop_hold_req", PKT_REQ, 1);
                    check("drop_hold_blk", BLOCK_IDX, 1);
                end
                PKT_ACK = 1'b1;
                tick();
                PKT_ACK = 1'b0;
                check("drop_gap_req", PKT_REQ, 0);
                check("drop_gap_busy", BUSY, 1);
                tick();
                check("drop_idle_busy", BUSY, 0);
                check("drop_idle_req", PKT_REQ, 0);
                check("drop_idle_fidx", FRAME_IDX, 0);
                check("drop_idle_sfidx", SUPERFRAME_IDX, 0);
                check("drop_idle_blk", BLOCK_IDX, 0);
                drop_seen = 1;
                return;
            end
            d = $urandom_range(0, 3);
            repeat (d) begin
                tick();
                check("hold_req", PKT_REQ, 1);
                check("hold_type", PKT_TYPE, m_type);
                check("hold_block_idx", BLOCK_IDX, m_blk);
                check("hold_frame_start", FRAME_START, 0);
            end
            PKT_ACK = 1'b1;
            model_advance();
            tick();
            // Occasionally leave ACK high into the GAP cycle; it must be ignored.
            PKT_ACK = ($urandom_range(0, 3) == 0);
        end
        PKT_ACK = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check_reset("reset");
        RST = 1'b0;
        tick();
        check_reset("idle");

        set_cfg(2, 2);
        model_start();
        ENA = 1'b1;
        run_requests(30, 1'b0, -1, 15);
        run_requests(20, 1'b1, -1, 0);
        check("drop_seen", drop_seen, 1);

        model_start();
        ENA = 1'b1;
        run_requests(12, 1'b0, -1, 10);
        run_requests(10, 1'b0, 2, 0);
        check("rst_seen", rst_seen, 1);

        set_cfg(0, 0);
        model_start();
        ENA = 1'b1;
        run_requests(40, 1'b0, -1, 0);

        for (int r = 0; r < 4; r++) begin
            RST = 1'b1; ENA = 1'b0; PKT_ACK = 1'b0; BBF_READY = 1'b1;
            tick();
            tick();
            check_reset("round_reset");
            RST = 1'b0;
            set_cfg($urandom_range(0, 4), $urandom_range(0, 4));
            model_start();
            ENA = 1'b1;
            run_requests(25, 1'b0, -1, 10);
        end

`ifndef T2MI_TIMESTAMP_EN
        check("ts_type_seen", ts_seen, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
